// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle MIPS controller (master) and its datapath (slave).
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;
    logic       pcwrite;
    logic       irwrite;
    logic       memwrite;
    logic       iord;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [1:0] immext;
    logic       jal;
    logic       instret;
    logic       illegal;
    logic       buserr;

    modport master (
        input  op, funct, zero, memready,
        output pcwrite, irwrite, memwrite, iord, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, alucontrol, immext, jal, instret, illegal, buserr
    );

    modport slave (
        output op, funct, zero, memready,
        input  pcwrite, irwrite, memwrite, iord, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, alucontrol, immext, jal, instret, illegal, buserr
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore-style sequencer for a multicycle MIPS datapath with memory-ready stall and timeout.
// Optional JAL support is enabled by defining MIPS_CTRL_JAL_EN.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 into PC on memready
// DECODE   | branch target into ALUOut, dispatch on opcode
// MEMADR   | compute lw/sw effective address
// MEMRD    | load data read, wait for memready
// MEMWB    | write load data to rt
// MEMWR    | store data write, wait for memready
// RTYPE_EX | R-type ALU operation
// ALU_WB   | write ALU result to rd
// BRANCH   | beq compare, conditional PC load from ALUOut
// IMM_EX   | addi/andi/ori ALU operation
// IMM_WB   | write ALU result to rt
// JUMP     | PC <- jump target
// JAL      | PC <- jump target, $31 <- PC
// HALT     | memory timeout, wait for reset
module mips_multicycle_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input logic clk,
    input logic reset,
    mips_multicycle_ctrl_if.master bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX,
        ALU_WB, BRANCH, IMM_EX, IMM_WB, JUMP, JAL, HALT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;
    logic             jal_en;
    logic             op_known;
    logic             rtype_ok;
    logic [2:0]       rtype_alu;

`ifdef MIPS_CTRL_JAL_EN
    assign jal_en = 1'b1;
`else
    assign jal_en = 1'b0;
`endif

    // The increment that would land on TIMEOUT diverts to HALT instead.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        op_known = 1'b0;
        case (bus.op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ,
            OP_ADDI, OP_ANDI, OP_ORI, OP_J: op_known = 1'b1;
            OP_JAL:                         op_known = jal_en;
            default:                        op_known = 1'b0;
        endcase
    end

    always_comb begin
        rtype_ok  = 1'b1;
        rtype_alu = 3'b000;
        case (bus.funct)
            6'b100000: rtype_alu = 3'b010;
            6'b100010: rtype_alu = 3'b110;
            6'b100100: rtype_alu = 3'b000;
            6'b100101: rtype_alu = 3'b001;
            6'b101010: rtype_alu = 3'b111;
            default:   rtype_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= '0;
            case (state)
                FETCH: begin
                    if (bus.memready)     state <= DECODE;
                    else if (timeout_hit) state <= HALT;
                    else                  wait_cnt <= wait_cnt + CNT_W'(1);
                end
                MEMRD: begin
                    if (bus.memready)     state <= MEMWB;
                    else if (timeout_hit) state <= HALT;
                    else                  wait_cnt <= wait_cnt + CNT_W'(1);
                end
                MEMWR: begin
                    if (bus.memready)     state <= FETCH;
                    else if (timeout_hit) state <= HALT;
                    else                  wait_cnt <= wait_cnt + CNT_W'(1);
                end
                DECODE: begin
                    if (!op_known) state <= FETCH;
                    else begin
                        case (bus.op)
                            OP_LW, OP_SW:              state <= MEMADR;
                            OP_RTYPE:                  state <= RTYPE_EX;
                            OP_BEQ:                    state <= BRANCH;
                            OP_ADDI, OP_ANDI, OP_ORI:  state <= IMM_EX;
                            OP_J:                      state <= JUMP;
                            OP_JAL:                    state <= JAL;
                            default:                   state <= FETCH;
                        endcase
                    end
                end
                MEMADR:   state <= (bus.op == OP_LW) ? MEMRD : MEMWR;
                RTYPE_EX: state <= rtype_ok ? ALU_WB : FETCH;
                IMM_EX:   state <= IMM_WB;
                HALT:     state <= HALT;
                default:  state <= FETCH;
            endcase
        end
    end

    // Outputs decode from state and are forced low while reset is held, so
    // an in-flight memwrite drops as soon as reset asserts.
    always_comb begin
        bus.pcwrite    = 1'b0;
        bus.irwrite    = 1'b0;
        bus.memwrite   = 1'b0;
        bus.iord       = 1'b0;
        bus.regwrite   = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.alucontrol = 3'b000;
        bus.immext     = 2'b00;
        bus.jal        = 1'b0;
        bus.instret    = 1'b0;
        bus.illegal    = 1'b0;
        bus.buserr     = 1'b0;
        if (reset) begin
            case (state)
                FETCH: begin
                    bus.alusrcb    = 2'b01;
                    bus.alucontrol = 3'b010;
                    bus.irwrite    = bus.memready;
                    bus.pcwrite    = bus.memready;
                end
                DECODE: begin
                    bus.alusrcb    = 2'b11;
                    bus.alucontrol = 3'b010;
                    bus.illegal    = !op_known;
                end
                MEMADR: begin
                    bus.alusrca    = 1'b1;
                    bus.alusrcb    = 2'b10;
                    bus.alucontrol = 3'b010;
                end
                MEMRD: bus.iord = 1'b1;
                MEMWB: begin
                    bus.memtoreg = 1'b1;
                    bus.regwrite = 1'b1;
                    bus.instret  = 1'b1;
                end
                MEMWR: begin
                    bus.iord     = 1'b1;
                    bus.memwrite = 1'b1;
                    bus.instret  = bus.memready;
                end
                RTYPE_EX: begin
                    bus.alusrca    = 1'b1;
                    bus.alucontrol = rtype_alu;
                    bus.illegal    = !rtype_ok;
                end
                ALU_WB: begin
                    bus.regdst   = 1'b1;
                    bus.regwrite = 1'b1;
                    bus.instret  = 1'b1;
                end
                BRANCH: begin
                    bus.alusrca    = 1'b1;
                    bus.alucontrol = 3'b110;
                    bus.pcsrc      = 2'b01;
                    bus.pcwrite    = bus.zero;
                    bus.instret    = 1'b1;
                end
                IMM_EX: begin
                    bus.alusrca = 1'b1;
                    bus.alusrcb = 2'b10;
                    case (bus.op)
                        OP_ANDI: begin bus.alucontrol = 3'b000; bus.immext = 2'b01; end
                        OP_ORI:  begin bus.alucontrol = 3'b001; bus.immext = 2'b01; end
                        default: begin bus.alucontrol = 3'b010; bus.immext = 2'b00; end
                    endcase
                end
                IMM_WB: begin
                    bus.regwrite = 1'b1;
                    bus.instret  = 1'b1;
                end
                JUMP: begin
                    bus.pcsrc   = 2'b10;
                    bus.pcwrite = 1'b1;
                    bus.instret = 1'b1;
                end
                JAL: begin
                    bus.jal      = jal_en;
                    bus.regwrite = jal_en;
                    bus.pcsrc    = jal_en ? 2'b10 : 2'b00;
                    bus.pcwrite  = jal_en;
                    bus.instret  = jal_en;
                end
                HALT:    bus.buserr = 1'b1;
                default: bus.buserr = 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl (TIMEOUT=4); define MIPS_CTRL_JAL_EN to cover JAL.
module tb_mips_multicycle_ctrl;
    // Output vector layout:
    // {pcwrite,irwrite,memwrite,iord,regwrite,regdst,memtoreg,alusrca,alusrcb,pcsrc,alucontrol,immext,jal,instret,illegal,buserr}
    localparam logic [20:0] E_ZERO    = '0;
    localparam logic [20:0] E_FW      = {8'b0000_0000, 2'b01, 2'b00, 3'b010, 2'b00, 4'b0000};
    localparam logic [20:0] E_FR      = {8'b1100_0000, 2'b01, 2'b00, 3'b010, 2'b00, 4'b0000};
    localparam logic [20:0] E_DEC     = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 2'b00, 4'b0000};
    localparam logic [20:0] E_DEC_ILL = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 2'b00, 4'b0010};
    localparam logic [20:0] E_MA      = {8'b0000_0001, 2'b10, 2'b00, 3'b010, 2'b00, 4'b0000};
    localparam logic [20:0] E_MR      = {8'b0001_0000, 2'b00, 2'b00, 3'b000, 2'b00, 4'b0000};
    localparam logic [20:0] E_MWB     = {8'b0000_1010, 2'b00, 2'b00, 3'b000, 2'b00, 4'b0100};
    localparam logic [20:0] E_MWW     = {8'b0011_0000, 2'b00, 2'b00, 3'b000, 2'b00, 4'b0000};
    localparam logic [20:0] E_MWR     = {8'b0011_0000, 2'b00, 2'b00, 3'b000, 2'b00, 4'b0100};
    localparam logic [20:0] E_ALUWB   = {8'b0000_1100, 2'b00, 2'b00, 3'b000, 2'b00, 4'b0100};
    localparam logic [20:0] E_RT_ILL  = {8'b0000_0001, 2'b00, 2'b00, 3'b000, 2'b00, 4'b0010};
    localparam logic [20:0] E_BR1     = {8'b1000_0001, 2'b00, 2'b01, 3'b110, 2'b00, 4'b0100};
    localparam logic [20:0] E_BR0     = {8'b0000_0001, 2'b00, 2'b01, 3'b110, 2'b00, 4'b0100};
    localparam logic [20:0] E_IMMWB   = {8'b0000_1000, 2'b00, 2'b00, 3'b000, 2'b00, 4'b0100};
    localparam logic [20:0] E_JUMP    = {8'b1000_0000, 2'b00, 2'b10, 3'b000, 2'b00, 4'b0100};
    localparam logic [20:0] E_JAL     = {8'b1000_1000, 2'b00, 2'b10, 3'b000, 2'b00, 4'b1100};
    localparam logic [20:0] E_HALT    = {8'b0000_0000, 2'b00, 2'b00, 3'b000, 2'b00, 4'b0001};

    logic clk;
    logic reset;
    int   checks;
    int   passes;
    logic [20:0] obs_tab [16];

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [20:0] outs();
        return {bus.pcwrite, bus.irwrite, bus.memwrite, bus.iord, bus.regwrite, bus.regdst,
                bus.memtoreg, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.immext,
                bus.jal, bus.instret, bus.illegal, bus.buserr};
    endfunction

    function automatic logic [20:0] rt_exp(input logic [2:0] alu);
        return {8'b0000_0001, 2'b00, 2'b00, alu, 2'b00, 4'b0000};
    endfunction

    function automatic logic [20:0] imm_exp(input logic [2:0] alu, input logic [1:0] ext);
        return {8'b0000_0001, 2'b10, 2'b00, alu, ext, 4'b0000};
    endfunction

    // Entered and left at posedge+1; memready for cycle i is mrv[i]; outputs sampled at negedge.
    task automatic drive_seq(input int n, input logic [15:0] mrv);
        for (int i = 0; i < n; i++) begin
            bus.memready = mrv[i];
            @(negedge clk);
            obs_tab[i] = outs();
            @(posedge clk);
            #1;
        end
        bus.memready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.op = 6'b101011; bus.funct = '0; bus.zero = 1'b0; bus.memready = 1'b0;
        @(negedge clk);
        checks++;
        if (outs() !== E_ZERO) $display("FAIL reset_outputs: got %h want %h", outs(), E_ZERO);
        else passes++;
        bus.memready = 1'b1;
        @(negedge clk);
        checks++;
        if (outs() !== E_ZERO) $display("FAIL reset_memready: got %h want %h", outs(), E_ZERO);
        else passes++;
        @(posedge clk);
        #1;
        bus.memready = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_lw();
        logic [20:0] e [10] = '{E_FW, E_FW, E_FW, E_FR, E_DEC, E_MA, E_MR, E_MR, E_MR, E_MWB};
        int n_ir, n_ret;
        n_ir = 0; n_ret = 0;
        bus.op = 6'b100011;
        drive_seq(10, 16'h0128);
        for (int i = 0; i < 10; i++) begin
            n_ir  += int'(obs_tab[i][19]);
            n_ret += int'(obs_tab[i][2]);
            checks++;
            if (obs_tab[i] !== e[i]) $display("FAIL lw_cycle%0d: got %h want %h", i, obs_tab[i], e[i]);
            else passes++;
        end
        checks++;
        if (n_ir !== 1) $display("FAIL lw_irwrite_count: got %0d want 1", n_ir);
        else passes++;
        checks++;
        if (n_ret !== 1) $display("FAIL lw_instret_count: got %0d want 1", n_ret);
        else passes++;
    endtask

    task automatic test_sw_reset();
        logic [20:0] e1 [4] = '{E_FR, E_DEC, E_MA, E_MWW};
        logic [20:0] e2 [5] = '{E_FW, E_FR, E_DEC, E_MA, E_MWR};
        bus.op = 6'b101011;
        drive_seq(4, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_tab[i] !== e1[i]) $display("FAIL sw_pre_cycle%0d: got %h want %h", i, obs_tab[i], e1[i]);
            else passes++;
        end
        reset = 1'b0;
        #1;
        checks++;
        if (outs() !== E_ZERO) $display("FAIL sw_async_reset: got %h want %h", outs(), E_ZERO);
        else passes++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive_seq(5, 16'h0012);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs_tab[i] !== e2[i]) $display("FAIL sw_post_cycle%0d: got %h want %h", i, obs_tab[i], e2[i]);
            else passes++;
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fn  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0] alu [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        logic [20:0] e [4];
        logic [20:0] ei [3] = '{E_FR, E_DEC, E_RT_ILL};
        bus.op = 6'b000000;
        for (int k = 0; k < 5; k++) begin
            bus.funct = fn[k];
            e = '{E_FR, E_DEC, rt_exp(alu[k]), E_ALUWB};
            drive_seq(4, 16'h0001);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_tab[i] !== e[i])
                    $display("FAIL rtype_f%b_cycle%0d: got %h want %h", fn[k], i, obs_tab[i], e[i]);
                else passes++;
            end
        end
        bus.funct = 6'b000111;
        drive_seq(3, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_tab[i] !== ei[i]) $display("FAIL rtype_illegal_cycle%0d: got %h want %h", i, obs_tab[i], ei[i]);
            else passes++;
        end
        bus.funct = '0;
    endtask

    task automatic test_branch();
        logic [20:0] e [3];
        bus.op = 6'b000100;
        for (int z = 1; z >= 0; z--) begin
            bus.zero = z[0];
            e = '{E_FR, E_DEC, (z == 1) ? E_BR1 : E_BR0};
            drive_seq(3, 16'h0001);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_tab[i] !== e[i]) $display("FAIL beq_z%0d_cycle%0d: got %h want %h", z, i, obs_tab[i], e[i]);
                else passes++;
            end
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_imm();
        logic [5:0] ops [3] = '{6'b001101, 6'b001000, 6'b001100};
        logic [2:0] alu [3] = '{3'b001, 3'b010, 3'b000};
        logic [1:0] ext [3] = '{2'b01, 2'b00, 2'b01};
        logic [20:0] e [4];
        for (int k = 0; k < 3; k++) begin
            bus.op = ops[k];
            e = '{E_FR, E_DEC, imm_exp(alu[k], ext[k]), E_IMMWB};
            drive_seq(4, 16'h0001);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_tab[i] !== e[i]) $display("FAIL imm_op%b_cycle%0d: got %h want %h", ops[k], i, obs_tab[i], e[i]);
                else passes++;
            end
        end
    endtask

    task automatic test_jump();
        logic [20:0] e [3] = '{E_FR, E_DEC, E_JUMP};
        bus.op = 6'b000010;
        drive_seq(3, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_tab[i] !== e[i]) $display("FAIL jump_cycle%0d: got %h want %h", i, obs_tab[i], e[i]);
            else passes++;
        end
    endtask

    task automatic test_illegal_op();
        logic [20:0] e [2] = '{E_FR, E_DEC_ILL};
`ifdef MIPS_CTRL_JAL_EN
        logic [20:0] ej [3] = '{E_FR, E_DEC, E_JAL};
`else
        logic [20:0] ej [2] = '{E_FR, E_DEC_ILL};
`endif
        bus.op = 6'b111111;
        drive_seq(2, 16'h0001);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_tab[i] !== e[i]) $display("FAIL illegal_op_cycle%0d: got %h want %h", i, obs_tab[i], e[i]);
            else passes++;
        end
        bus.op = 6'b000011;
        drive_seq($size(ej), 16'h0001);
        for (int i = 0; i < $size(ej); i++) begin
            checks++;
            if (obs_tab[i] !== ej[i]) $display("FAIL jal_op_cycle%0d: got %h want %h", i, obs_tab[i], ej[i]);
            else passes++;
        end
    endtask

    task automatic test_timeout();
        logic [20:0] e [10] = '{E_FR, E_DEC, E_MA, E_MR, E_MR, E_MR, E_MR, E_HALT, E_HALT, E_HALT};
        bus.op = 6'b100011;
        drive_seq(10, 16'h0081);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs_tab[i] !== e[i]) $display("FAIL timeout_cycle%0d: got %h want %h", i, obs_tab[i], e[i]);
            else passes++;
        end
        reset = 1'b0;
        #1;
        checks++;
        if (outs() !== E_ZERO) $display("FAIL halt_reset: got %h want %h", outs(), E_ZERO);
        else passes++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (outs() !== E_FW) $display("FAIL post_halt_fetch: got %h want %h", outs(), E_FW);
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_lw();
        test_sw_reset();
        test_rtype();
        test_branch();
        test_imm();
        test_jump();
        test_illegal_op();
        test_timeout();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
